flag_branch_ctrl: RTL and testbench
===================================

# flag_branch_ctrl

Condition-flag register and branch-resolution controller for the pipelined CPU. Holds the architectural NZCV flags written by flag-setting instructions in EX and resolves B, CBZ and B.LT branches in ID. The CBZ zero test comes from the zero-detect unit on the forwarded source operand. Sequences the flag-use hazard by bypass or by a one-cycle stall, and issues the registered IF flush and a taken-branch count.

## Interface
Parameters:
- CNT_W, 16, width of taken-branch counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- ex_setflags  in  1  EX instruction writes flags (ADDS/SUBS/ANDS)
- alu_negative, alu_zero, alu_carry, alu_overflow  in  1 each  EX ALU flag outputs; alu_zero from the 64-bit zero detector
- id_br_valid  in  1  ID holds a branch
- id_br_type  in  2  00 B, 01 CBZ, 10 B.LT, 11 reserved
- id_cbz_zero  in  1  zero-detect of CBZ source register (forwarded value)
- flags_q  out  4  architectural {N,Z,C,V}
- stall  out  1  hold PC/IF/ID, insert bubble into EX
- br_resolved  out  1  branch decided this cycle
- br_taken  out  1  decided branch is taken (valid with br_resolved)
- flush  out  1  registered one-cycle IF squash
- br_count  out  CNT_W  taken-branch count, wraps

## Operation
- Flag write: at posedge, if ex_valid & ex_setflags, flags_q <= {alu_negative, alu_zero, alu_carry, alu_overflow}; otherwise hold.
- Squash: while flush=1, id_br_valid is ignored; stall=0, br_resolved=0, FSM not affected.
- Hazard: hz = id_br_valid & (id_br_type==10) & ex_valid & ex_setflags & !flush, evaluated in state IDLE only.
- FSM states IDLE, WAIT:
  - IDLE, hz, macro off: stall=1, br_resolved=0, next WAIT.
  - IDLE, other branch or macro on: resolve this cycle, stay IDLE.
  - WAIT: stall=0; resolve held B.LT from flags_q (ignore EX inputs for resolution); next IDLE unconditionally.
- Resolution (br_resolved=1): taken = B:1; CBZ: id_cbz_zero; B.LT: N^V from selected flag source; 11: 0 (resolved, not taken).
- Flag source for B.LT in IDLE: EX ALU outputs when hz and bypass enabled, else flags_q.
- flush <= br_resolved & br_taken at each posedge; a one-cycle pulse per taken branch.
- br_count increments by 1 on the same condition; wraps from all-ones to 0 with no saturation.
- Flag write and branch resolution in the same cycle are independent; the flag register still updates.

## Timing
- Reset values: flags_q=0000, flush=0, br_count=0, FSM=IDLE. stall, br_resolved and br_taken are 0 during reset.
- Reset is asynchronous. Assertion in WAIT returns to IDLE immediately and drops stall/outputs without waiting for a clock.
- stall, br_resolved and br_taken are combinational from inputs and state, with zero cycles of latency.
- flags_q, flush and br_count have one cycle of latency.
- Hazard with macro off: B.LT resolves exactly one cycle after first presentation, and stall is high for exactly one cycle.
- A branch in ID the cycle after a taken branch is squashed because flush=1 in that cycle.
- flush asserts the cycle after br_taken and lasts exactly one cycle. Back-to-back taken branches cannot occur because the second one is squashed.

## Configuration
- FLAG_BYPASS_EN defined: B.LT behind a flag-setting EX instruction uses alu_negative^alu_overflow in the same cycle. There is no stall, and WAIT is unreachable.
- Undefined: the same case takes the one-cycle stall through WAIT and resolves from flags_q.
- All other behaviour is identical in both builds.

## Test plan
- Reset mid-WAIT (macro off): assert reset during WAIT -> stall=0 immediately, flags_q=0000, br_count=0, no flush after release.
- SUBS in EX with N=1,V=0, B.LT in ID, macro off -> cycle 0: stall=1, br_resolved=0. Cycle 1: flags_q=1000, br_resolved=1, br_taken=1. Cycle 2: flush=1, br_count=1.
- Same stimulus, macro on -> cycle 0: stall=0, br_taken=1. Cycle 1: flush=1, flags_q=1000.
- CBZ with id_cbz_zero=0 then 1 in consecutive cycles -> first: br_resolved=1, br_taken=0. Second: taken. Next cycle: flush=1.
- Taken B, then B in ID during flush cycle -> second branch ignored: br_resolved=0, no second flush, br_count=1.
- CNT_W=4 and 16 taken branches -> br_count counts 1 through 15, then wraps to 0. Reserved type 11 -> br_resolved=1, br_taken=0, count unchanged.

Source files
------------

// File: rtl/flag_branch_ctrl.sv
// NZCV flag register and ID-stage branch resolver with flag-use hazard sequencing.
// Build option: define FLAG_BYPASS_EN to resolve B.LT from the EX ALU flags instead of stalling.
module flag_branch_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_setflags,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             id_br_valid,
    input  logic [1:0]       id_br_type,
    input  logic             id_cbz_zero,
    output logic [3:0]       flags_q,
    output logic             stall,
    output logic             br_resolved,
    output logic             br_taken,
    output logic             flush,
    output logic [CNT_W-1:0] br_count
);

    localparam logic [1:0] BR_B   = 2'b00;
    localparam logic [1:0] BR_CBZ = 2'b01;
    localparam logic [1:0] BR_LT  = 2'b10;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_nxt;
    logic   flag_wr_p0;
    logic   hz;
    logic   lt_flags;
    logic   lt_ex;

    function automatic logic branch_taken(input logic [1:0] br_type,
                                          input logic       cbz_zero,
                                          input logic       lt);
        logic t;
        case (br_type)
            BR_B:    t = 1'b1;
            BR_CBZ:  t = cbz_zero;
            BR_LT:   t = lt;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign flag_wr_p0 = ex_valid & ex_setflags;
    assign hz         = id_br_valid & (id_br_type == BR_LT) & flag_wr_p0 & ~flush;
    assign lt_flags   = flags_q[3] ^ flags_q[0];
    assign lt_ex      = alu_negative ^ alu_overflow;

    always_comb begin
        stall       = 1'b0;
        br_resolved = 1'b0;
        br_taken    = 1'b0;
        state_nxt   = state;
        if (!reset) begin
            case (state)
                IDLE: begin
                    // A squashed ID slot is invisible to both resolution and the FSM.
                    if (id_br_valid && !flush) begin
`ifdef FLAG_BYPASS_EN
                        br_resolved = 1'b1;
                        br_taken    = branch_taken(id_br_type, id_cbz_zero,
                                                   hz ? lt_ex : lt_flags);
`else
                        if (hz) begin
                            stall     = 1'b1;
                            state_nxt = WAIT;
                        end else begin
                            br_resolved = 1'b1;
                            br_taken    = branch_taken(id_br_type, id_cbz_zero, lt_flags);
                        end
`endif
                    end
                end
                WAIT: begin
                    // The held B.LT now sees the flags written by the instruction it waited on.
                    br_resolved = 1'b1;
                    br_taken    = lt_flags;
                    state_nxt   = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p1: architectural flags, FSM state, flush pulse and taken count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            flags_q  <= 4'b0000;
            flush    <= 1'b0;
            br_count <= '0;
        end else begin
            state <= state_nxt;
            if (flag_wr_p0) begin
                flags_q <= {alu_negative, alu_zero, alu_carry, alu_overflow};
            end
            flush <= br_resolved & br_taken;
            if (br_resolved && br_taken) begin
                br_count <= br_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Directed bench for flag_branch_ctrl: vector table plus hazard, squash, reset and wrap sequences.
module tb_flag_branch_ctrl;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid, ex_setflags;
    logic             alu_negative, alu_zero, alu_carry, alu_overflow;
    logic             id_br_valid;
    logic [1:0]       id_br_type;
    logic             id_cbz_zero;
    logic [3:0]       flags_q;
    logic             stall, br_resolved, br_taken, flush;
    logic [CNT_W-1:0] br_count;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] exp_count;

    typedef struct {
        logic       ev;
        logic       es;
        logic [3:0] nzcv;
        logic       bv;
        logic [1:0] bt;
        logic       cbz;
        logic       e_res;
        logic       e_tk;
        logic [3:0] e_flags;
    } vec_t;

    vec_t vecs[12];

    flag_branch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_setflags(ex_setflags),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .id_br_valid(id_br_valid), .id_br_type(id_br_type), .id_cbz_zero(id_cbz_zero),
        .flags_q(flags_q), .stall(stall), .br_resolved(br_resolved),
        .br_taken(br_taken), .flush(flush), .br_count(br_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic ev, input logic es, input logic [3:0] nzcv,
                         input logic bv, input logic [1:0] bt, input logic cbz);
        ex_valid     = ev;
        ex_setflags  = es;
        alu_negative = nzcv[3];
        alu_zero     = nzcv[2];
        alu_carry    = nzcv[1];
        alu_overflow = nzcv[0];
        id_br_valid  = bv;
        id_br_type   = bt;
        id_cbz_zero  = cbz;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        //             ev    es    nzcv     bv    bt     cbz   res   tk    flags
        vecs[0]  = '{1'b1, 1'b1, 4'b1000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1000};
        vecs[1]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 4'b1000};
        vecs[2]  = '{1'b1, 1'b1, 4'b1001, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 4'b1001};
        vecs[3]  = '{1'b1, 1'b0, 4'b0110, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 4'b1001};
        vecs[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 4'b1001};
        vecs[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 4'b1001};
        vecs[6]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 4'b1001};
        vecs[7]  = '{1'b0, 1'b1, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1001};
        vecs[8]  = '{1'b1, 1'b1, 4'b0001, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 4'b0001};
        vecs[9]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[10] = '{1'b0, 1'b1, 4'b1000, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[11] = '{1'b1, 1'b1, 4'b0100, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0100};

        // Reset, with a branch presented to confirm outputs are held low
        reset = 1'b1;
        apply(1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 1'b0);
        exp_count = '0;
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_res", 32'(br_resolved), 32'd0);
        chk("rst_taken", 32'(br_taken), 32'd0);
        @(negedge clk);
        chk("rst_flags", 32'(flags_q), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_count", 32'(br_count), 32'd0);
        reset = 1'b0;
        idle();

        // Table of single-cycle vectors, each followed by an idle cycle
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            apply(vecs[i].ev, vecs[i].es, vecs[i].nzcv, vecs[i].bv, vecs[i].bt, vecs[i].cbz);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            chk($sformatf("v%0d_res", i), 32'(br_resolved), 32'(vecs[i].e_res));
            chk($sformatf("v%0d_taken", i), 32'(br_taken), 32'(vecs[i].e_tk));
            @(negedge clk);
            idle();
            #1;
            if (vecs[i].e_tk) exp_count = exp_count + 1'b1;
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_tk));
            chk($sformatf("v%0d_count", i), 32'(br_count), 32'(exp_count));
            chk($sformatf("v%0d_flags", i), 32'(flags_q), 32'(vecs[i].e_flags));
        end

        // SUBS (N=1,V=0) in EX with B.LT in ID; flags_q starts at 0000
        @(negedge clk);
        apply(1'b1, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        apply(1'b1, 1'b1, 4'b1000, 1'b1, 2'b10, 1'b0);
        #1;
`ifdef FLAG_BYPASS_EN
        chk("hz_c0_stall", 32'(stall), 32'd0);
        chk("hz_c0_res", 32'(br_resolved), 32'd1);
        chk("hz_c0_taken", 32'(br_taken), 32'd1);
        @(negedge clk);
        idle();
        #1;
        exp_count = exp_count + 1'b1;
        chk("hz_c1_flush", 32'(flush), 32'd1);
        chk("hz_c1_flags", 32'(flags_q), 32'b1000);
        chk("hz_c1_count", 32'(br_count), 32'(exp_count));
`else
        chk("hz_c0_stall", 32'(stall), 32'd1);
        chk("hz_c0_res", 32'(br_resolved), 32'd0);
        @(negedge clk);
        apply(1'b0, 1'b0, 4'b0000, 1'b1, 2'b10, 1'b0);
        #1;
        chk("hz_c1_flags", 32'(flags_q), 32'b1000);
        chk("hz_c1_stall", 32'(stall), 32'd0);
        chk("hz_c1_res", 32'(br_resolved), 32'd1);
        chk("hz_c1_taken", 32'(br_taken), 32'd1);
        chk("hz_c1_flush", 32'(flush), 32'd0);
        @(negedge clk);
        idle();
        #1;
        exp_count = exp_count + 1'b1;
        chk("hz_c2_flush", 32'(flush), 32'd1);
        chk("hz_c2_count", 32'(br_count), 32'(exp_count));
`endif
        @(negedge clk);
        #1;
        chk("hz_flush_end", 32'(flush), 32'd0);

        // Asynchronous reset one cycle into the hazard sequence
        @(negedge clk);
        apply(1'b1, 1'b1, 4'b1000, 1'b1, 2'b10, 1'b0);
        @(negedge clk);
        apply(1'b0, 1'b0, 4'b0000, 1'b1, 2'b10, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_res", 32'(br_resolved), 32'd0);
        chk("arst_taken", 32'(br_taken), 32'd0);
        chk("arst_flags", 32'(flags_q), 32'd0);
        chk("arst_count", 32'(br_count), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        exp_count = '0;
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(negedge clk);
        #1;
        chk("arst_post_flush", 32'(flush), 32'd0);
        chk("arst_post_count", 32'(br_count), 32'd0);

        // Sixteen taken branches wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            apply(1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 1'b0);
            @(negedge clk);
            idle();
            #1;
            exp_count = exp_count + 1'b1;
            chk($sformatf("wrap%0d_count", i), 32'(br_count), 32'((i + 1) % 16));
        end
        @(negedge clk);
        apply(1'b0, 1'b0, 4'b0000, 1'b1, 2'b11, 1'b0);
        #1;
        chk("rsv_res", 32'(br_resolved), 32'd1);
        chk("rsv_taken", 32'(br_taken), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("rsv_flush", 32'(flush), 32'd0);
        chk("rsv_count", 32'(br_count), 32'(exp_count));

        // Taken B, then a B.LT behind a flag setter during the flush cycle is squashed
        @(negedge clk);
        apply(1'b0, 1'b0, 4'b0000, 1'b1, 2'b00, 1'b0);
        #1;
        chk("sq_c0_res", 32'(br_resolved), 32'd1);
        chk("sq_c0_taken", 32'(br_taken), 32'd1);
        @(negedge clk);
        apply(1'b1, 1'b1, 4'b1000, 1'b1, 2'b10, 1'b0);
        #1;
        exp_count = exp_count + 1'b1;
        chk("sq_c1_flush", 32'(flush), 32'd1);
        chk("sq_c1_stall", 32'(stall), 32'd0);
        chk("sq_c1_res", 32'(br_resolved), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("sq_c2_flush", 32'(flush), 32'd0);
        chk("sq_c2_count", 32'(br_count), 32'(exp_count));
        chk("sq_c2_res", 32'(br_resolved), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
